// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : decode_scoreboard
// Description : Decode-stage register scoreboard. Tracks pending register
//               writes, detects RAW / WAW / structural hazards, and drives
//               issue, stall and bubble controls with a RUN/STALL/FLUSH FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_scoreboard #(
    parameter int WB_BYPASS    = 1,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic        i_rs1_used,
    input  logic        i_rs2_used,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_rd_wen,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_addr,
    input  logic        i_flush,
    output logic        o_issue,
    output logic        o_stall,
    output logic        o_bubble,
    output logic [31:0] o_pending,
    output logic [3:0]  o_inflight,
    output logic [15:0] o_stall_count
);

    localparam logic [3:0] C_MAX_INFLIGHT = 4'(MAX_INFLIGHT);
    localparam logic       C_BYPASS       = (WB_BYPASS != 0);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pending;
    logic [31:0] w_pending_nxt;
    logic [3:0]  r_inflight;
    logic [3:0]  w_inflight_nxt;
    logic [15:0] r_stall_count;

    logic w_wb_clr;
    logic w_raw1;
    logic w_raw2;
    logic w_waw;
    logic w_struct;
    logic w_hazard;
    logic w_set;

    // A writeback only retires something if it targets a pending, nonzero register
    assign w_wb_clr = i_wb_valid & (i_wb_addr != 5'd0) & r_pending[i_wb_addr];

    // A hazard on a register vanishes when bypass is enabled and that register is written back now
    assign w_raw1 = i_rs1_used & (i_rs1_addr != 5'd0) & r_pending[i_rs1_addr]
                  & ~(C_BYPASS & i_wb_valid & (i_wb_addr == i_rs1_addr));
    assign w_raw2 = i_rs2_used & (i_rs2_addr != 5'd0) & r_pending[i_rs2_addr]
                  & ~(C_BYPASS & i_wb_valid & (i_wb_addr == i_rs2_addr));
    assign w_waw  = i_rd_wen & (i_rd_addr != 5'd0) & r_pending[i_rd_addr]
                  & ~(C_BYPASS & i_wb_valid & (i_wb_addr == i_rd_addr));
    // A retiring write frees a tracking slot in the same cycle
    assign w_struct = i_rd_wen & (i_rd_addr != 5'd0)
                    & (r_inflight == C_MAX_INFLIGHT) & ~w_wb_clr;

    // Decode-side fields are meaningless without i_valid
    assign w_hazard = i_valid & (w_raw1 | w_raw2 | w_waw | w_struct);

    assign o_issue  = i_valid & ~w_hazard & ~i_flush & (r_state != ST_FLUSH);
    assign o_stall  = i_valid &  w_hazard & ~i_flush & (r_state != ST_FLUSH);
    assign o_bubble = ~o_issue;

    assign w_set = o_issue & i_rd_wen & (i_rd_addr != 5'd0);

    assign o_pending     = r_pending;
    assign o_inflight    = r_inflight;
    assign o_stall_count = r_stall_count;

    // Next-state logic: flush dominates, FLUSH lasts one cycle
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN:   if (o_stall)  w_state_nxt = ST_STALL;
                ST_STALL: if (!o_stall) w_state_nxt = ST_RUN;
                ST_FLUSH: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    // Pending bitmap and in-flight count; set is applied last so it wins
    always_comb begin
        w_pending_nxt  = r_pending;
        w_inflight_nxt = r_inflight;
        if (w_wb_clr) w_pending_nxt[i_wb_addr] = 1'b0;
        if (w_set)    w_pending_nxt[i_rd_addr] = 1'b1;
        w_pending_nxt[0] = 1'b0;
        case ({w_set, w_wb_clr})
            2'b10:   w_inflight_nxt = r_inflight + 4'd1;
            2'b01:   w_inflight_nxt = r_inflight - 4'd1;
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    // State, scoreboard and saturating stall counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pending     <= 32'd0;
            r_inflight    <= 4'd0;
            r_stall_count <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_inflight <= w_inflight_nxt;
            if (o_stall && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_scoreboard
// Description : Directed self-checking bench for decode_scoreboard, with a
//               bypass instance and a no-bypass instance on shared inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_rs1_used, i_rs2_used, i_rd_wen, i_wb_valid, i_flush;
    logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr, i_wb_addr;
    logic        o_issue, o_stall, o_bubble;
    logic [31:0] o_pending;
    logic [3:0]  o_inflight;
    logic [15:0] o_stall_count;
    logic        n_issue, n_stall, n_bubble;
    logic [31:0] n_pending;
    logic [3:0]  n_inflight;
    logic [15:0] n_stall_count;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [1:0] C_RUN   = 2'd0;
    localparam logic [1:0] C_STALL = 2'd1;
    localparam logic [1:0] C_FLUSH = 2'd2;

    decode_scoreboard #(.WB_BYPASS(1), .MAX_INFLIGHT(3)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
        .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen),
        .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_flush(i_flush),
        .o_issue(o_issue), .o_stall(o_stall), .o_bubble(o_bubble),
        .o_pending(o_pending), .o_inflight(o_inflight), .o_stall_count(o_stall_count)
    );

    decode_scoreboard #(.WB_BYPASS(0), .MAX_INFLIGHT(3)) dut_nb (
        .clk(clk), .rst(rst), .i_valid(i_valid),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
        .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen),
        .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_flush(i_flush),
        .o_issue(n_issue), .o_stall(n_stall), .o_bubble(n_bubble),
        .o_pending(n_pending), .o_inflight(n_inflight), .o_stall_count(n_stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wen,
                         input logic wbv, input logic [4:0] wba, input logic fl);
        i_valid = v; i_rs1_addr = rs1; i_rs1_used = u1;
        i_rs2_addr = rs2; i_rs2_used = u2; i_rd_addr = rd; i_rd_wen = wen;
        i_wb_valid = wbv; i_wb_addr = wba; i_flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("rst_pending",  o_pending, 32'd0);
        chk("rst_inflight", o_inflight, 4'd0);
        chk("rst_stallcnt", o_stall_count, 16'd0);
        chk("rst_issue",    o_issue, 1'b0);
        chk("rst_bubble",   o_bubble, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // RAW on x5 resolved by same-cycle writeback (bypass)
        @(negedge clk); drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); #1;
        chk("w5_issue", o_issue, 1'b1);
        @(posedge clk); #1;
        chk("w5_pending", o_pending, 32'h20);
        chk("w5_inflight", o_inflight, 4'd1);
        @(negedge clk); drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("raw5_stall", o_stall, 1'b1);
        chk("raw5_issue", o_issue, 1'b0);
        @(posedge clk); #1;
        chk("raw5_state", dut.r_state, C_STALL);
        chk("raw5_stallcnt", o_stall_count, 16'd1);
        @(negedge clk); drive(1, 5, 1, 0, 0, 0, 0, 1, 5, 0); #1;
        chk("byp5_issue", o_issue, 1'b1);
        chk("byp5_stall", o_stall, 1'b0);
        @(posedge clk); #1;
        chk("byp5_pending", o_pending, 32'd0);
        chk("byp5_inflight", o_inflight, 4'd0);
        chk("byp5_state", dut.r_state, C_RUN);

        // Same sequence without bypass: stall holds through the wb cycle
        rst_pulse();
        @(negedge clk); drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); #1;
        chk("nb_w5_issue", n_issue, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("nb_raw5_stall", n_stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); drive(1, 5, 1, 0, 0, 0, 0, 1, 5, 0); #1;
        chk("nb_wb_stall", n_stall, 1'b1);
        chk("nb_wb_issue", n_issue, 1'b0);
        @(posedge clk); #1;
        chk("nb_wb_pending", n_pending, 32'd0);
        chk("nb_wb_state", dut_nb.r_state, C_STALL);
        @(negedge clk); drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("nb_after_issue", n_issue, 1'b1);
        @(posedge clk); #1;
        chk("nb_stallcnt", n_stall_count, 16'd2);

        // Structural hazard at MAX_INFLIGHT, freed by a retiring writeback
        rst_pulse();
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk); drive(1, 0, 0, 0, 0, 5'(r), 1, 0, 0, 0); #1;
            chk("fill_issue", o_issue, 1'b1);
            @(posedge clk); #1;
        end
        chk("fill_inflight", o_inflight, 4'd3);
        chk("fill_pending", o_pending, 32'h0E);
        @(negedge clk); drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); #1;
        chk("struct_stall", o_stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); drive(1, 0, 0, 0, 0, 4, 1, 1, 1, 0); #1;
        chk("struct_wb_issue", o_issue, 1'b1);
        @(posedge clk); #1;
        chk("struct_inflight", o_inflight, 4'd3);
        chk("struct_pending", o_pending, 32'h1C);

        // Flush during STALL: two bubble cycles, pending untouched
        @(negedge clk); drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("fl_pre_stall", o_stall, 1'b1);
        @(posedge clk); #1;
        chk("fl_pre_state", dut.r_state, C_STALL);
        @(negedge clk); drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("fl_issue", o_issue, 1'b0);
        chk("fl_bubble", o_bubble, 1'b1);
        chk("fl_stall", o_stall, 1'b0);
        @(posedge clk); #1;
        chk("fl_state", dut.r_state, C_FLUSH);
        chk("fl_pending", o_pending, 32'h1C);
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("fls_issue", o_issue, 1'b0);
        chk("fls_bubble", o_bubble, 1'b1);
        @(posedge clk); #1;
        chk("fls_state", dut.r_state, C_RUN);
        @(negedge clk); #1;
        chk("post_fl_issue", o_issue, 1'b1);

        // Writes to x0, wb to non-pending/x0, and invalid decode are ignored
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); #1;
        chk("x0_issue", o_issue, 1'b1);
        @(posedge clk); #1;
        chk("x0_pending", o_pending, 32'h1C);
        chk("x0_inflight", o_inflight, 4'd3);
        @(negedge clk); drive(0, 0, 0, 0, 0, 7, 1, 1, 9, 0);
        @(posedge clk); #1;
        chk("wb9_pending", o_pending, 32'h1C);
        chk("wb9_inflight", o_inflight, 4'd3);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        chk("wb0_inflight", o_inflight, 4'd3);

        // Same register set and cleared together ends set
        @(negedge clk); drive(1, 0, 0, 0, 0, 2, 1, 1, 2, 0); #1;
        chk("sc_issue", o_issue, 1'b1);
        @(posedge clk); #1;
        chk("sc_pending", o_pending, 32'h1C);
        chk("sc_inflight", o_inflight, 4'd3);

        // Long rs2 hazard saturates the stall counter, then reset mid-stall
        @(negedge clk); drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); #1;
        chk("rs2_stall", o_stall, 1'b1);
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stallcnt", o_stall_count, 16'hFFFF);
        chk("sat_stall", o_stall, 1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_pending", o_pending, 32'd0);
        chk("mrst_inflight", o_inflight, 4'd0);
        chk("mrst_stallcnt", o_stall_count, 16'd0);
        chk("mrst_stall", o_stall, 1'b0);
        chk("mrst_issue", o_issue, 1'b1);
        chk("mrst_bubble", o_bubble, 1'b0);
        chk("mrst_state", dut.r_state, C_RUN);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_issue", o_issue, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_scoreboard.md
DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 SHALL have parameter WB_BYPASS, default 1; when 1, a same-cycle writeback to a source register resolves that register's hazard.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 3; maximum number of issued, not-yet-retired register writes (range 1..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_valid  input  1  decoded instruction present in decode.
REQ-006 i_rs1_addr, i_rs2_addr  input  5 each  source register addresses.
REQ-007 i_rs1_used, i_rs2_used  input  1 each  instruction reads that source.
REQ-008 i_rd_addr  input  5  destination register address.
REQ-009 i_rd_wen  input  1  instruction writes i_rd_addr.
REQ-010 i_wb_valid, i_wb_addr  input  1, 5  writeback retiring a write to i_wb_addr this cycle.
REQ-011 i_flush  input  1  control redirect (branch taken, jal, jalr); kills the instruction in decode.
REQ-012 o_issue  output  1  instruction in decode advances this cycle.
REQ-013 o_stall  output  1  fetch/decode hold this cycle.
REQ-014 o_bubble  output  1  downstream receives a NOP this cycle.
REQ-015 o_pending  output  32  per-register pending-write bitmap; bit 0 always 0.
REQ-016 o_inflight  output  4  count of outstanding writes.
REQ-017 o_stall_count  output  16  saturating count of stall cycles.

Function
REQ-018 SHALL implement states RUN, STALL, FLUSH (2-bit encoding, implementer's choice).
REQ-019 A source is hazarded when used, address nonzero, pending bit set, and not cleared this cycle; it is cleared this cycle only when WB_BYPASS=1 and i_wb_valid with matching i_wb_addr.
REQ-020 WAW hazard: i_rd_wen, i_rd_addr nonzero, and i_rd_addr pending, with the same-cycle clear rule as REQ-019.
REQ-021 Structural hazard: i_rd_wen, i_rd_addr nonzero, and o_inflight == MAX_INFLIGHT with no retiring writeback this cycle.
REQ-022 hazard = RAW(rs1) | RAW(rs2) | WAW | structural; combinational from current inputs and state.
REQ-023 o_issue = i_valid & ~hazard & ~i_flush & (state != FLUSH).
REQ-024 o_stall = i_valid & hazard & ~i_flush & (state != FLUSH).
REQ-025 o_bubble = ~o_issue.
REQ-026 Transitions: any state with i_flush -> FLUSH; FLUSH -> RUN after exactly one cycle; RUN with o_stall -> STALL; STALL with ~o_stall -> RUN; otherwise hold.
REQ-027 A pending bit SHALL be set on o_issue with i_rd_wen and nonzero i_rd_addr.
REQ-028 A pending bit SHALL be cleared on i_wb_valid for a pending i_wb_addr; writeback to a non-pending register or x0 SHALL be ignored.
REQ-029 Same register set and cleared in the same cycle SHALL end set (set wins).
REQ-030 o_inflight increments on each set and decrements on each effective clear; a simultaneous set and clear leaves it unchanged; it never exceeds MAX_INFLIGHT or underflows.
REQ-031 o_stall_count increments on each o_stall cycle and saturates at 16'hFFFF.
REQ-032 i_flush SHALL NOT clear pending bits; older instructions still retire.
REQ-033 Decode-side inputs SHALL be ignored when i_valid=0; writeback inputs are always honoured.

Reset
REQ-034 On rst SHALL immediately force state RUN, o_pending=0, o_inflight=0, and o_stall_count=0, with o_issue, o_stall, o_bubble following REQ-023..025 combinationally.
REQ-035 Reset asserted mid-stall SHALL discard all pending writes; the first post-reset instruction issues without hazard.

Verification
REQ-036 Issue write x5; next cycle read x5 with no writeback -> o_stall=1, state STALL; wb x5 with WB_BYPASS=1 -> o_issue=1 that cycle, o_pending[5]=0.
REQ-037 Same as REQ-036 with WB_BYPASS=0 -> stall persists through the wb cycle; issue on the following cycle.
REQ-038 Issue writes x1, x2, x3 (MAX_INFLIGHT=3); fourth writes x4 -> stall; wb x1 -> o_issue=1 same cycle, o_inflight stays 3.
REQ-039 i_flush during STALL -> o_issue=0, o_bubble=1 for 2 cycles (flush cycle and FLUSH cycle); pending bits unchanged; RUN afterward.
REQ-040 Write to x0 or wb to a non-pending register -> o_pending and o_inflight unchanged.
REQ-041 Hold a hazard for 70000 cycles -> o_stall_count=16'hFFFF; assert rst mid-stall -> all outputs zero except o_bubble/o_issue per REQ-025.
